// File: rtl/lab_pkg.sv
// Shared fetch-stage types and constants for the LEGv8 pipeline.
package lab_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    // ADDI XZR, XZR, #0 -- the pipeline bubble
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h910003FF;

    // Next-PC source returned by the decode stage; 2'b11 is reserved
    typedef enum logic [1:0] {
        BR_SEQ = 2'b00,
        BR_REL = 2'b01,
        BR_REG = 2'b10
    } br_sel_e;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/branch_target_calc.sv
// PC-relative branch target from the instruction sitting in IF/ID.
module branch_target_calc
    import lab_pkg::*;
(
    input  logic [INSTR_W-1:0] id_instr,
    input  logic [ADDR_W-1:0]  id_pc,
    input  logic               uncond_br,
    output logic [ADDR_W-1:0]  rel_target
);

    logic [ADDR_W-1:0] offset;
    logic              unused_instr_bits;

    // Opcode and condition/Rt fields do not affect the target
    assign unused_instr_bits = ^{id_instr[31:26], id_instr[4:0]};

    // Pick BrAddr26 or CondAddr19, sign-extend, scale to bytes
    always_comb begin
        if (uncond_br)
            offset = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
        else
            offset = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};
    end

    // 64-bit add, wraps silently
    assign rel_target = id_pc + offset;

endmodule

// File: rtl/instr_fetch_stage.sv
// LEGv8 fetch stage: PC register, instruction-memory address, IF/ID register.
module instr_fetch_stage
    import lab_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          DELAY_SLOT = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic [1:0]         br_taken,
    input  logic               uncond_br,
    input  logic [ADDR_W-1:0]  br_reg_target,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus4,
    output logic               id_valid
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              squash;
    ifid_t             ifid;

    branch_target_calc u_btc (
        .id_instr   (ifid.instr),
        .id_pc      (ifid.pc),
        .uncond_br  (uncond_br),
        .rel_target (rel_target)
    );

    assign pc_plus4  = pc + 64'd4;
    assign imem_addr = pc;
    assign squash    = redirect && (DELAY_SLOT == 0);

    // Next-PC select; reserved encoding falls back to sequential
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        case (br_taken)
            BR_REL: begin
                next_pc  = rel_target;
                redirect = 1'b1;
            end
            BR_REG: begin
                next_pc  = br_reg_target;
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

    // PC and IF/ID update: reset, then stall-hold, then fetch/redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            ifid.instr    <= NOP_INSTR;
            ifid.pc       <= '0;
            ifid.pc_plus4 <= '0;
            ifid.valid    <= 1'b0;
        end else if (!stall) begin
            pc            <= next_pc;
            ifid.instr    <= squash ? NOP_INSTR : imem_data;
            ifid.pc       <= pc;
            ifid.pc_plus4 <= pc_plus4;
            ifid.valid    <= !squash;
        end
    end

    assign id_instr    = ifid.instr;
    assign id_pc       = ifid.pc;
    assign id_pc_plus4 = ifid.pc_plus4;
    assign id_valid    = ifid.valid;

    // Decode must never hand back the reserved branch encoding
    a_no_reserved_br : assert property (@(posedge clk) disable iff (reset)
        !(!stall && br_taken == 2'b11));

endmodule
